user_core_nmi_arb: RTL and testbench
====================================

USER_CORE_NMI_ARB -- requirements
Module: user_core_nmi_arb

Interface
REQ-001 SHALL have parameter ID, default 5'd31, core slot identifier (carried unchanged, no function inside block).
REQ-002 SHALL have parameter TIMEOUT, default 256, cycles nmi_valid_o may wait for nmi_ready_i before abort (range 2..65535).
REQ-003 SHALL have port clk_i input 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i input 1, reset, synchronous, active-high.
REQ-005 SHALL have ports inst_req_i input 1, inst_addr_i input 32, inst_data_o output 32, inst_ack_o output 1: CPU instruction fetch channel.
REQ-006 SHALL have ports data_req_i input 1, data_addr_i input 32, data_wdata_i input 32, data_wstrb_i input 4, data_wr_i input 1, data_rdata_o output 32, data_ack_o output 1: CPU load/store channel.
REQ-007 SHALL have ports nmi_valid_o output 1, nmi_ready_i input 1, nmi_addr_o output 32, nmi_wdata_o output 32, nmi_wstrb_o output 4, nmi_rdata_i input 32: native memory master.
REQ-008 SHALL have port timeout_o output 1: one-cycle pulse on aborted transaction.

Function
REQ-009 CPU channels: req held high until one-cycle ack pulse; requester may drop or change req in cycle after ack.
REQ-010 NMI: transaction = valid high with stable addr/wdata/wstrb until ready sampled high; ready cycle carries nmi_rdata_i; wstrb 4'h0 = read.
REQ-011 FSM states IDLE, BUSY, RESP; exactly one transaction outstanding.
REQ-012 IDLE: if any req high, grant one channel, register addr/wdata/wstrb, go BUSY; else stay.
REQ-013 Arbitration: only one req -> that one; both -> channel not granted last (round-robin); last_grant updates on each grant.
REQ-014 Instruction grant: nmi_wstrb_o 4'h0, nmi_wdata_o 32'h0.
REQ-015 Data grant: data_wr_i=1 -> nmi_wstrb_o=data_wstrb_i, nmi_wdata_o=data_wdata_i; data_wr_i=0 -> wstrb 4'h0; data_wr_i=1 with strobe 4'h0 issued unchanged (no-op write).
REQ-016 BUSY: nmi_valid_o=1, registered outputs stable; nmi_ready_i=1 -> capture nmi_rdata_i, go RESP.
REQ-017 Timeout counter cleared on grant, increments each BUSY cycle with ready low; ready low on the TIMEOUT-th BUSY cycle -> abort: capture 32'hDEAD_BEEF as read data, go RESP, timeout_o=1 in RESP cycle.
REQ-018 Ready and counter limit same cycle: ready wins, no timeout.
REQ-019 RESP (one cycle): nmi_valid_o=0; granted channel ack=1 with registered data on its data output; other ack 0; next IDLE.
REQ-020 Req ignored during RESP, so a held req is not re-issued before ack is seen.
REQ-021 Latency: grant in IDLE cycle N -> nmi_valid_o cycle N+1; ready cycle M -> ack M+1; earliest next grant M+2, next valid M+3.
REQ-022 inst_data_o/data_rdata_o hold last captured value outside ack cycles; writes capture nmi_rdata_i as returned.
REQ-023 Request inputs change during BUSY: no effect on outstanding transaction.

Reset
REQ-024 rst_i high at clock edge -> state IDLE, nmi_valid_o 0, nmi_addr_o/nmi_wdata_o 32'h0, nmi_wstrb_o 4'h0, both acks 0, inst_data_o/data_rdata_o 32'h0, timeout_o 0, counter 0, last_grant=instruction (data wins first tie).
REQ-025 Reset mid-transaction (BUSY or RESP) SHALL abandon it with no ack issued; nmi_valid_o low next cycle.

Verification
REQ-026 Fetch: inst_req_i=1, addr 32'h0000_0100, ready after 3 wait cycles, rdata 32'h0000_0013 -> valid 4 cycles, wstrb 0, inst_ack_o 1 cycle after ready with inst_data_o 32'h0000_0013.
REQ-027 Tie after reset: both reqs same cycle -> data served first, instruction next; reqs held continuously -> grants alternate D,I,D,I.
REQ-028 Store: data_wr_i=1, addr 32'h1000_0004, wdata 32'hA5A5_5A5A, wstrb 4'b0011, ready immediate -> nmi_wstrb_o 4'b0011, data_ack_o exactly 2 cycles after request sampled.
REQ-029 Timeout: TIMEOUT=8, ready never high -> valid 8 cycles, then ack with 32'hDEAD_BEEF and timeout_o pulse; ready on 8th cycle -> normal completion, no timeout_o.
REQ-030 Reset in BUSY: assert rst_i one cycle -> no ack, valid low, next request still obeys REQ-021 timing.

Source files
------------

// File: rtl/user_core_nmi_arb.sv
// Round-robin arbiter joining the CPU fetch and load/store channels onto one
// native memory master; one transaction in flight, aborted after TIMEOUT waits.
module user_core_nmi_arb #(
    parameter int unsigned ID      = 5'd31,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        inst_req_i,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_data_o,
    output logic        inst_ack_o,

    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_wstrb_i,
    input  logic        data_wr_i,
    output logic [31:0] data_rdata_o,
    output logic        data_ack_o,

    output logic        nmi_valid_o,
    input  logic        nmi_ready_i,
    output logic [31:0] nmi_addr_o,
    output logic [31:0] nmi_wdata_o,
    output logic [3:0]  nmi_wstrb_o,
    input  logic [31:0] nmi_rdata_i,

    output logic        timeout_o
);

    localparam logic [15:0] CNT_LAST   = 16'(TIMEOUT - 1);
    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

    // ID is a slot tag carried for the integrator; only its range is checked here.
    if (TIMEOUT < 2 || TIMEOUT > 65535 || ID > 31) begin : g_bad_param
        $error("user_core_nmi_arb: TIMEOUT must be 2..65535 and ID must fit 5 bits");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t      r_state;
    logic        r_last_data;
    logic        r_sel_data;
    logic [15:0] r_cnt;
    logic        r_valid;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_inst_ack;
    logic        r_data_ack;
    logic [31:0] r_inst_data;
    logic [31:0] r_data_rdata;
    logic        r_timeout;

    logic        w_any_req;
    logic        w_grant_data;
    logic        w_data_write;
    logic [31:0] w_resp_data;

    assign w_any_req    = inst_req_i | data_req_i;
    // On a tie the channel that lost the previous grant wins this one.
    assign w_grant_data = data_req_i & (~inst_req_i | ~r_last_data);
    assign w_data_write = w_grant_data & data_wr_i;
    assign w_resp_data  = nmi_ready_i ? nmi_rdata_i : ABORT_DATA;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_last_data  <= 1'b0;
            r_sel_data   <= 1'b0;
            r_cnt        <= '0;
            r_valid      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_inst_ack   <= 1'b0;
            r_data_ack   <= 1'b0;
            r_inst_data  <= '0;
            r_data_rdata <= '0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= ST_BUSY;
                        r_valid     <= 1'b1;
                        r_sel_data  <= w_grant_data;
                        r_last_data <= w_grant_data;
                        r_cnt       <= '0;
                        r_addr      <= w_grant_data ? data_addr_i : inst_addr_i;
                        r_wdata     <= w_data_write ? data_wdata_i : '0;
                        r_wstrb     <= w_data_write ? data_wstrb_i : '0;
                    end
                end
                ST_BUSY: begin
                    // Ready on the last allowed cycle still completes normally.
                    if (nmi_ready_i || r_cnt == CNT_LAST) begin
                        r_state   <= ST_RESP;
                        r_valid   <= 1'b0;
                        r_timeout <= ~nmi_ready_i;
                        if (r_sel_data) begin
                            r_data_ack   <= 1'b1;
                            r_data_rdata <= w_resp_data;
                        end else begin
                            r_inst_ack  <= 1'b1;
                            r_inst_data <= w_resp_data;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    r_state    <= ST_IDLE;
                    r_inst_ack <= 1'b0;
                    r_data_ack <= 1'b0;
                    r_timeout  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign nmi_valid_o  = r_valid;
    assign nmi_addr_o   = r_addr;
    assign nmi_wdata_o  = r_wdata;
    assign nmi_wstrb_o  = r_wstrb;
    assign inst_ack_o   = r_inst_ack;
    assign data_ack_o   = r_data_ack;
    assign inst_data_o  = r_inst_data;
    assign data_rdata_o = r_data_rdata;
    assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_user_core_nmi_arb.sv
// Bench for user_core_nmi_arb: hand sequences, a vector table and random
// transactions checked against a transaction-level arbitration model.
module tb_user_core_nmi_arb;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        inst_req_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_data_o;
    logic        inst_ack_o;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [3:0]  data_wstrb_i;
    logic        data_wr_i;
    logic [31:0] data_rdata_o;
    logic        data_ack_o;
    logic        nmi_valid_o;
    logic        nmi_ready_i;
    logic [31:0] nmi_addr_o;
    logic [31:0] nmi_wdata_o;
    logic [3:0]  nmi_wstrb_o;
    logic [31:0] nmi_rdata_i;
    logic        timeout_o;

    user_core_nmi_arb #(.ID(5'd3), .TIMEOUT(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .inst_req_i   (inst_req_i),
        .inst_addr_i  (inst_addr_i),
        .inst_data_o  (inst_data_o),
        .inst_ack_o   (inst_ack_o),
        .data_req_i   (data_req_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_wstrb_i (data_wstrb_i),
        .data_wr_i    (data_wr_i),
        .data_rdata_o (data_rdata_o),
        .data_ack_o   (data_ack_o),
        .nmi_valid_o  (nmi_valid_o),
        .nmi_ready_i  (nmi_ready_i),
        .nmi_addr_o   (nmi_addr_o),
        .nmi_wdata_o  (nmi_wdata_o),
        .nmi_wstrb_o  (nmi_wstrb_o),
        .nmi_rdata_i  (nmi_rdata_i),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: who was served last, and what each channel last returned.
    logic        last_d;
    logic [31:0] hold_i;
    logic [31:0] hold_d;

    typedef struct {
        logic       ir;
        logic       dr;
        logic       wr;
        logic [3:0] st;
        int         w;
        logic       exp_d;
        logic [3:0] exp_st;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        inst_req_i   = 1'b0;
        inst_addr_i  = '0;
        data_req_i   = 1'b0;
        data_addr_i  = '0;
        data_wdata_i = '0;
        data_wstrb_i = '0;
        data_wr_i    = 1'b0;
        nmi_ready_i  = 1'b0;
        nmi_rdata_i  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_i = 1'b1;
        step();
        step();
        rst_i  = 1'b0;
        last_d = 1'b0;
        hold_i = '0;
        hold_d = '0;
    endtask

    task automatic idle_check(input int n, input string tag);
        inst_req_i = 1'b0;
        data_req_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, ".idle_valid"}, nmi_valid_o, 1'b0);
            chk({tag, ".idle_ack"}, {inst_ack_o, data_ack_o}, 2'b00);
        end
    endtask

    // Called in an IDLE cycle with requests driven; w = wait cycles before ready
    // (w >= TO means ready never comes). Returns in the cycle after the ack.
    task automatic txn(input int w, input logic [31:0] rd, input logic exp_d,
                       input logic [3:0] exp_st, input string tag);
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        logic        e_to;
        logic        chk_wd;
        e_addr = exp_d ? data_addr_i : inst_addr_i;
        chk_wd = !exp_d || data_wr_i;
        e_wd   = exp_d ? data_wdata_i : 32'h0;
        e_to   = (w >= int'(TO));
        e_rd   = e_to ? 32'hDEAD_BEEF : rd;
        last_d = exp_d;
        step();
        for (int k = 0; k < int'(TO); k++) begin
            chk({tag, ".valid"}, nmi_valid_o, 1'b1);
            chk({tag, ".addr"}, nmi_addr_o, e_addr);
            chk({tag, ".wstrb"}, nmi_wstrb_o, exp_st);
            if (chk_wd) chk({tag, ".wdata"}, nmi_wdata_o, e_wd);
            chk({tag, ".ack_busy"}, {inst_ack_o, data_ack_o}, 2'b00);
            // Changing request fields mid-transaction must not disturb it.
            inst_addr_i  = $urandom;
            data_addr_i  = $urandom;
            data_wdata_i = $urandom;
            data_wstrb_i = 4'($urandom);
            data_wr_i    = 1'($urandom);
            nmi_ready_i  = (k == w);
            nmi_rdata_i  = (k == w) ? rd : $urandom;
            step();
            nmi_ready_i = 1'b0;
            if (k == w) break;
        end
        chk({tag, ".resp_valid"}, nmi_valid_o, 1'b0);
        chk({tag, ".inst_ack"}, inst_ack_o, !exp_d);
        chk({tag, ".data_ack"}, data_ack_o, exp_d);
        chk({tag, ".timeout"}, timeout_o, e_to);
        if (exp_d) hold_d = e_rd;
        else       hold_i = e_rd;
        chk({tag, ".inst_data"}, inst_data_o, hold_i);
        chk({tag, ".data_rdata"}, data_rdata_o, hold_d);
        step();
        chk({tag, ".ack_clear"}, {inst_ack_o, data_ack_o, timeout_o}, 3'b000);
        chk({tag, ".inst_hold"}, inst_data_o, hold_i);
        chk({tag, ".data_hold"}, data_rdata_o, hold_d);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       m_d;
        logic [3:0] m_st;
        int         v;
        int         w;

        do_reset();
        chk("rst.valid", nmi_valid_o, 1'b0);
        chk("rst.addr", nmi_addr_o, 32'h0);
        chk("rst.wdata", nmi_wdata_o, 32'h0);
        chk("rst.wstrb", nmi_wstrb_o, 4'h0);
        chk("rst.acks", {inst_ack_o, data_ack_o}, 2'b00);
        chk("rst.inst_data", inst_data_o, 32'h0);
        chk("rst.data_rdata", data_rdata_o, 32'h0);
        chk("rst.timeout", timeout_o, 1'b0);

        // Fetch with three wait cycles.
        inst_req_i  = 1'b1;
        inst_addr_i = 32'h0000_0100;
        txn(3, 32'h0000_0013, 1'b0, 4'h0, "fetch");
        inst_req_i = 1'b0;

        // Store completing immediately: ack two cycles after request sampled.
        data_req_i   = 1'b1;
        data_wr_i    = 1'b1;
        data_addr_i  = 32'h1000_0004;
        data_wdata_i = 32'hA5A5_5A5A;
        data_wstrb_i = 4'b0011;
        txn(0, 32'h1234_5678, 1'b1, 4'b0011, "store");
        data_req_i = 1'b0;
        idle_check(2, "gap");

        // Tie after reset with both requests held: D, I, D, I.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            inst_req_i   = 1'b1;
            data_req_i   = 1'b1;
            inst_addr_i  = 32'h0000_2000 + 32'(i);
            data_addr_i  = 32'h0000_3000 + 32'(i);
            data_wr_i    = 1'b0;
            txn(i, 32'hC0DE_0000 + 32'(i), (i % 2) == 0, 4'h0, "tie");
        end
        inst_req_i = 1'b0;
        data_req_i = 1'b0;

        // Timeout boundary: no ready aborts; ready on the last cycle completes.
        inst_req_i  = 1'b1;
        inst_addr_i = 32'h0000_4000;
        txn(TO + 3, 32'h0, 1'b0, 4'h0, "tmo_abort");
        inst_addr_i = 32'h0000_4004;
        txn(TO - 1, 32'h0BAD_F00D, 1'b0, 4'h0, "tmo_edge");
        inst_req_i = 1'b0;

        // Reset while BUSY abandons the transaction.
        inst_req_i  = 1'b1;
        inst_addr_i = 32'h0000_0200;
        step();
        chk("rstbusy.valid1", nmi_valid_o, 1'b1);
        step();
        chk("rstbusy.valid2", nmi_valid_o, 1'b1);
        rst_i      = 1'b1;
        nmi_ready_i = 1'b0;
        step();
        rst_i      = 1'b0;
        inst_req_i = 1'b0;
        chk("rstbusy.valid_low", nmi_valid_o, 1'b0);
        chk("rstbusy.no_ack", {inst_ack_o, data_ack_o}, 2'b00);
        last_d = 1'b0;
        hold_i = '0;
        hold_d = '0;
        idle_check(3, "rstbusy");
        inst_req_i  = 1'b1;
        data_req_i  = 1'b1;
        data_wr_i   = 1'b0;
        data_addr_i = 32'h0000_5000;
        txn(1, 32'h5555_AAAA, 1'b1, 4'h0, "rstbusy.after");
        inst_req_i = 1'b0;
        data_req_i = 1'b0;

        // Vector table, applied back to back from a fresh reset.
        vecs[0] = '{ir:1'b1, dr:1'b0, wr:1'b0, st:4'h0, w:0,      exp_d:1'b0, exp_st:4'h0};
        vecs[1] = '{ir:1'b0, dr:1'b1, wr:1'b0, st:4'hF, w:2,      exp_d:1'b1, exp_st:4'h0};
        vecs[2] = '{ir:1'b1, dr:1'b1, wr:1'b1, st:4'hF, w:1,      exp_d:1'b0, exp_st:4'h0};
        vecs[3] = '{ir:1'b1, dr:1'b1, wr:1'b1, st:4'hF, w:0,      exp_d:1'b1, exp_st:4'hF};
        vecs[4] = '{ir:1'b0, dr:1'b1, wr:1'b1, st:4'h0, w:3,      exp_d:1'b1, exp_st:4'h0};
        vecs[5] = '{ir:1'b0, dr:1'b1, wr:1'b1, st:4'h8, w:TO - 1, exp_d:1'b1, exp_st:4'h8};
        vecs[6] = '{ir:1'b1, dr:1'b0, wr:1'b0, st:4'h0, w:TO + 5, exp_d:1'b0, exp_st:4'h0};
        vecs[7] = '{ir:1'b1, dr:1'b1, wr:1'b0, st:4'h3, w:TO,     exp_d:1'b1, exp_st:4'h0};
        vecs[8] = '{ir:1'b1, dr:1'b1, wr:1'b1, st:4'h5, w:1,      exp_d:1'b0, exp_st:4'h0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            inst_req_i   = vecs[i].ir;
            data_req_i   = vecs[i].dr;
            data_wr_i    = vecs[i].wr;
            data_wstrb_i = vecs[i].st;
            inst_addr_i  = $urandom;
            data_addr_i  = $urandom;
            data_wdata_i = $urandom;
            txn(vecs[i].w, $urandom, vecs[i].exp_d, vecs[i].exp_st, $sformatf("vec%0d", i));
        end
        idle_check(1, "vec_end");

        // Random traffic against the round-robin model.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 4) == 0) idle_check($urandom_range(1, 3), "rnd_gap");
            v            = $urandom_range(1, 3);
            inst_req_i   = v[0];
            data_req_i   = v[1];
            inst_addr_i  = $urandom;
            data_addr_i  = $urandom;
            data_wdata_i = $urandom;
            data_wstrb_i = 4'($urandom);
            data_wr_i    = 1'($urandom);
            if (inst_req_i && data_req_i) m_d = !last_d;
            else                          m_d = data_req_i;
            m_st = (m_d && data_wr_i) ? data_wstrb_i : 4'h0;
            v = $urandom_range(0, 9);
            if (v < 6)       w = v;
            else if (v == 6) w = TO - 1;
            else if (v == 7) w = TO + 2;
            else             w = $urandom_range(0, 2);
            txn(w, $urandom, m_d, m_st, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
